// File: rtl/prime_sweep_ctrl.sv
// Prime-search sequencer: sweeps candidates 2..NumMax and runs trial division on each
// through an external handshaked remainder unit. It counts and flags the primes it finds.
module prime_sweep_ctrl #(
  parameter int NW = 10,
  parameter int CW = 8
) (
  input  logic          SysClk,
  input  logic          Reset,
  input  logic          Start,
  input  logic [NW-1:0] NumMax,
  output logic [NW-1:0] Dividend,
  output logic [NW-1:0] Divisor,
  output logic          DivStart,
  input  logic          DivDone,
  input  logic [NW-1:0] DivRem,
  output logic          Prime,
  output logic [NW-1:0] NumberChecked,
  output logic [CW-1:0] NumberofPrimesFound,
  output logic          Busy,
  output logic          Done
);

  typedef enum logic [2:0] {S_IDLE, S_NEXT, S_ISSUE, S_WAIT, S_DECIDE, S_FINISH} state_t;

  state_t        state_q, state_d;
  logic [NW-1:0] max_q, max_d, cand_q, cand_d, d_q, d_d;
  logic [CW-1:0] count_q, count_d;
  logic          is_prime_q, is_prime_d;
  logic [NW-1:0] dividend_q, dividend_d, divisor_q, divisor_d, checked_q, checked_d;
  logic          div_start_q, div_start_d, prime_q, prime_d, busy_q, busy_d, done_q, done_d;

  logic [NW:0]     d_inc;
  logic [2*NW+1:0] inc_sq;
  assign d_inc  = {1'b0, d_q} + 1'b1;
  assign inc_sq = d_inc * d_inc;

  // Dividend/Divisor/DivStart load on the transition into ISSUE so the request
  // is visible on the ports exactly during the ISSUE cycle.
  always_comb begin
    state_d     = state_q;
    max_d       = max_q;
    cand_d      = cand_q;
    d_d         = d_q;
    count_d     = count_q;
    is_prime_d  = is_prime_q;
    dividend_d  = dividend_q;
    divisor_d   = divisor_q;
    checked_d   = checked_q;
    div_start_d = 1'b0;
    prime_d     = 1'b0;
    busy_d      = busy_q;
    done_d      = done_q;
    case (state_q)
      S_IDLE, S_FINISH: begin
        if (Start) begin
          max_d   = NumMax;
          cand_d  = NW'(2);
          count_d = '0;
          if (NumMax < NW'(2)) begin
            state_d = S_FINISH;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = S_NEXT;
            busy_d  = 1'b1;
            done_d  = 1'b0;
          end
        end
      end
      S_NEXT: begin
        d_d = NW'(2);
        if (cand_q < NW'(4)) begin
          is_prime_d = 1'b1;
          state_d    = S_DECIDE;
        end else begin
          is_prime_d  = 1'b0;
          state_d     = S_ISSUE;
          dividend_d  = cand_q;
          divisor_d   = NW'(2);
          div_start_d = 1'b1;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (DivDone) begin
          if (DivRem == '0) begin
            is_prime_d = 1'b0;
            state_d    = S_DECIDE;
          end else begin
            d_d = d_inc[NW-1:0];
            if (inc_sq > (2*NW+2)'(cand_q)) begin
              is_prime_d = 1'b1;
              state_d    = S_DECIDE;
            end else begin
              state_d     = S_ISSUE;
              dividend_d  = cand_q;
              divisor_d   = d_inc[NW-1:0];
              div_start_d = 1'b1;
            end
          end
        end
      end
      S_DECIDE: begin
        checked_d = cand_q;
        if (is_prime_q) begin
          prime_d = 1'b1;
          if (count_q != '1) count_d = count_q + 1'b1;
        end
        // Equality-only termination: the sweep never wraps past 2^NW-1.
        if (cand_q == max_q) begin
          state_d = S_FINISH;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cand_d  = cand_q + 1'b1;
          state_d = S_NEXT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge SysClk) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      max_q       <= '0;
      cand_q      <= '0;
      d_q         <= '0;
      count_q     <= '0;
      is_prime_q  <= 1'b0;
      dividend_q  <= '0;
      divisor_q   <= '0;
      checked_q   <= '0;
      div_start_q <= 1'b0;
      prime_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      max_q       <= max_d;
      cand_q      <= cand_d;
      d_q         <= d_d;
      count_q     <= count_d;
      is_prime_q  <= is_prime_d;
      dividend_q  <= dividend_d;
      divisor_q   <= divisor_d;
      checked_q   <= checked_d;
      div_start_q <= div_start_d;
      prime_q     <= prime_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign Dividend            = dividend_q;
  assign Divisor             = divisor_q;
  assign DivStart            = div_start_q;
  assign Prime               = prime_q;
  assign NumberChecked       = checked_q;
  assign NumberofPrimesFound = count_q;
  assign Busy                = busy_q;
  assign Done                = done_q;

endmodule

// File: tb/tb_prime_sweep_ctrl.sv
// Bench for prime_sweep_ctrl: behavioural remainder unit with fixed or random latency,
// reference prime lists and trial-division request lists computed from plain arithmetic.
module tb_prime_sweep_ctrl;
  localparam int NW = 10;
  localparam int CW = 8;

  logic          SysClk = 1'b0;
  logic          Reset, Start, DivStart, DivDone, Prime, Busy, Done;
  logic [NW-1:0] NumMax, Dividend, Divisor, DivRem, NumberChecked;
  logic [CW-1:0] NumberofPrimesFound;

  prime_sweep_ctrl #(.NW(NW), .CW(CW)) dut (
    .SysClk(SysClk), .Reset(Reset), .Start(Start), .NumMax(NumMax),
    .Dividend(Dividend), .Divisor(Divisor), .DivStart(DivStart),
    .DivDone(DivDone), .DivRem(DivRem), .Prime(Prime),
    .NumberChecked(NumberChecked), .NumberofPrimesFound(NumberofPrimesFound),
    .Busy(Busy), .Done(Done)
  );

  always #5 SysClk = ~SysClk;

  int checks = 0;
  int failures = 0;
  int lat_fix = 1;          // 0 selects a random latency 1..5 per request
  int prime_seen[$];
  int ds_seen[$];
  int ds_double = 0;
  bit prev_ds = 1'b0;
  int dl;
  logic [NW-1:0] da, db;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Remainder unit: answers L cycles after it sees DivStart, regardless of DUT state.
  initial begin
    DivDone = 1'b0;
    DivRem  = '0;
    forever begin
      @(posedge SysClk); #1;
      DivDone = 1'b0;
      if (DivStart === 1'b1) begin
        da = Dividend;
        db = Divisor;
        dl = (lat_fix == 0) ? int'($urandom_range(1, 5)) : lat_fix;
        repeat (dl) @(posedge SysClk);
        #1;
        DivDone = 1'b1;
        DivRem  = (db == 0) ? '0 : da % db;
      end
    end
  end

  always @(negedge SysClk) begin
    if (Reset === 1'b0) begin
      if (Prime === 1'b1) prime_seen.push_back(int'(NumberChecked));
      if (DivStart === 1'b1) begin
        ds_seen.push_back(int'(Dividend) * 1024 + int'(Divisor));
        if (prev_ds) ds_double++;
      end
    end
    prev_ds = (DivStart === 1'b1);
  end

  function automatic bit is_prime(int n);
    if (n < 2) return 1'b0;
    for (int k = 2; k * k <= n; k++) if (n % k == 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic pulse_start(input int nmax);
    NumMax = NW'(nmax);
    Start  = 1'b1;
    @(posedge SysClk); #1;
    Start  = 1'b0;
  endtask

  task automatic run_sweep(input int nmax, input int lat, input bit disturb, input string tag);
    int exp_pr[$];
    int exp_ds[$];
    int exp_cnt, mism, cyc, n;
    lat_fix = lat;
    prime_seen.delete();
    ds_seen.delete();
    ds_double = 0;
    for (int c = 2; c <= nmax; c++) begin
      if (is_prime(c)) exp_pr.push_back(c);
      for (int d = 2; d * d <= c; d++) begin
        exp_ds.push_back(c * 1024 + d);
        if (c % d == 0) break;
      end
    end
    exp_cnt = (exp_pr.size() > 255) ? 255 : exp_pr.size();
    pulse_start(nmax);
    if (nmax < 2) chk({tag, ":done_after_1cyc"}, Done, 1);
    cyc = 0;
    while (Done !== 1'b1 && cyc < 60000) begin
      if (disturb && cyc == 30) begin Start = 1'b1; NumMax = NW'(3); end
      else if (disturb && cyc == 31) Start = 1'b0;
      @(posedge SysClk); #1;
      cyc++;
    end
    Start = 1'b0;
    @(negedge SysClk);
    chk({tag, ":timeout"}, (cyc >= 60000), 0);
    chk({tag, ":done"}, Done, 1);
    chk({tag, ":busy"}, Busy, 0);
    chk({tag, ":count"}, NumberofPrimesFound, exp_cnt);
    if (nmax >= 2) chk({tag, ":last_checked"}, NumberChecked, nmax);
    chk({tag, ":n_primes"}, prime_seen.size(), exp_pr.size());
    n = (prime_seen.size() < exp_pr.size()) ? prime_seen.size() : exp_pr.size();
    mism = 0;
    for (int i = 0; i < n; i++) if (prime_seen[i] != exp_pr[i]) mism++;
    chk({tag, ":prime_list_mism"}, mism, 0);
    chk({tag, ":n_divstart"}, ds_seen.size(), exp_ds.size());
    n = (ds_seen.size() < exp_ds.size()) ? ds_seen.size() : exp_ds.size();
    mism = 0;
    for (int i = 0; i < n; i++) if (ds_seen[i] != exp_ds[i]) mism++;
    chk({tag, ":divstart_list_mism"}, mism, 0);
    chk({tag, ":divstart_multi_cycle"}, ds_double, 0);
  endtask

  initial begin
    int cyc;
    Reset  = 1'b1;
    Start  = 1'b0;
    NumMax = '0;
    repeat (3) @(posedge SysClk);
    #1;
    Reset = 1'b0;
    chk("rst:dividend", Dividend, 0);
    chk("rst:divisor", Divisor, 0);
    chk("rst:divstart", DivStart, 0);
    chk("rst:prime", Prime, 0);
    chk("rst:checked", NumberChecked, 0);
    chk("rst:count", NumberofPrimesFound, 0);
    chk("rst:busy", Busy, 0);
    chk("rst:done", Done, 0);

    run_sweep(10, 1, 1'b0, "t2_L1");
    run_sweep(10, 5, 1'b0, "t2_L5");
    run_sweep(0, 1, 1'b0, "t3_0_L1");
    run_sweep(1, 5, 1'b0, "t3_1_L5");
    run_sweep(1, 1, 1'b0, "t3_1_L1");
    run_sweep(0, 5, 1'b0, "t3_0_L5");
    run_sweep(505, 1, 1'b0, "t1_L1");
    run_sweep(505, 5, 1'b0, "t1_L5");
    run_sweep(1023, 1, 1'b0, "t4_L1");
    run_sweep(50, 1, 1'b1, "t6_L1");
    run_sweep(50, 5, 1'b1, "t6_L5");

    // Abort in WAIT while candidate 37 is under trial.
    lat_fix = 5;
    pulse_start(50);
    cyc = 0;
    while (!(DivStart === 1'b1 && Dividend == NW'(37)) && cyc < 20000) begin
      @(posedge SysClk); #1;
      cyc++;
    end
    chk("t5:reach_37", (cyc >= 20000), 0);
    @(posedge SysClk); #1;
    chk("t5:busy_in_wait", Busy, 1);
    Reset = 1'b1;
    @(posedge SysClk); #1;
    Reset = 1'b0;
    chk("t5:dividend", Dividend, 0);
    chk("t5:divisor", Divisor, 0);
    chk("t5:divstart", DivStart, 0);
    chk("t5:prime", Prime, 0);
    chk("t5:checked", NumberChecked, 0);
    chk("t5:count", NumberofPrimesFound, 0);
    chk("t5:busy", Busy, 0);
    chk("t5:done", Done, 0);
    repeat (8) @(posedge SysClk);
    #1;
    chk("t5:stray_busy", Busy, 0);
    chk("t5:stray_done", Done, 0);
    chk("t5:stray_divstart", DivStart, 0);
    run_sweep(20, 5, 1'b0, "t5_restart_L5");
    run_sweep(20, 1, 1'b0, "t5_restart_L1");

    for (int i = 0; i < 5; i++)
      run_sweep(int'($urandom_range(0, 90)), int'($urandom_range(0, 5)), 1'b0,
                $sformatf("rand%0d", i));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
